// File: rtl/sigmoid_backprop.sv
// Local sigmoid gradient: grad_out = grad_in * y * (1 - y), y in unsigned Q0.DATA_W.
// Latency: 2 cycles (S1 computes dsig, S2 is the output register), 1 sample/cycle.
// Backpressure: in_ready = !s1_valid || !out_valid || out_ready; holds 2 samples when stalled.
module sigmoid_backprop #(
    parameter int DATA_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] y,
    input  logic [DATA_W-1:0] grad_in,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] grad_out,
    output logic              out_last,
    output logic [CNT_W-1:0]  xfer_count
);

    // dsig peaks at 2^(DATA_W-2), so it needs DATA_W-1 bits.
    localparam int DSIG_W = DATA_W - 1;
    // y * (2^DATA_W - y) peaks at 2^(2*DATA_W-2); one spare bit keeps it simple.
    localparam int PROD_W = 2 * DATA_W + 1;
    // Signed gradient product: |grad_in| * dsig <= 2^(2*DATA_W-3).
    localparam int GP_W   = 2 * DATA_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Pipeline state
    logic                     r_s1_valid;
    logic [DSIG_W-1:0]        r_s1_dsig;
    logic signed [DATA_W-1:0] r_s1_grad;
    logic                     r_s1_last;
    logic                     r_out_valid;
    logic [DATA_W-1:0]        r_grad_out;
    logic                     r_out_last;
    logic [CNT_W-1:0]         r_xfer_count;

    // Combinational datapath and handshake
    logic                     w_s2_advance;
    logic                     w_s1_advance;
    logic                     w_out_xfer;
    logic [DATA_W:0]          w_comp;
    logic [DSIG_W-1:0]        w_dsig;
    logic signed [GP_W-1:0]   w_grad_prod;
    logic [DATA_W-1:0]        w_grad_next;

    assign w_s2_advance = !r_out_valid || out_ready;
    assign w_s1_advance = !r_s1_valid || w_s2_advance;
    assign w_out_xfer   = r_out_valid && out_ready;

    // (1 - y) in Q0.DATA_W; y = 0 gives exactly 2^DATA_W, hence the extra bit.
    assign w_comp = {1'b1, {DATA_W{1'b0}}} - {1'b0, y};
    // Truncation to DSIG_W is lossless: the shifted product never exceeds 2^(DATA_W-2).
    assign w_dsig = DSIG_W'((PROD_W'(y) * PROD_W'(w_comp)) >> DATA_W);

    // Sign-extend the gradient, zero-extend dsig, then floor via arithmetic shift.
    assign w_grad_prod = GP_W'(r_s1_grad) * $signed(GP_W'(r_s1_dsig));
    assign w_grad_next = DATA_W'(w_grad_prod >>> DATA_W);

    assign in_ready   = w_s1_advance;
    assign out_valid  = r_out_valid;
    assign grad_out   = r_grad_out;
    assign out_last   = r_out_last;
    assign xfer_count = r_xfer_count;

    // Stage 1: capture dsig, gradient and last flag whenever the stage can move.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_dsig  <= '0;
            r_s1_grad  <= '0;
            r_s1_last  <= 1'b0;
        end else if (w_s1_advance) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_dsig <= w_dsig;
                r_s1_grad <= $signed(grad_in);
                r_s1_last <= in_last;
            end
        end
    end

    // Stage 2: output register; data only changes when S1 hands over a valid sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_grad_out  <= '0;
            r_out_last  <= 1'b0;
        end else if (w_s2_advance) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_grad_out <= w_grad_next;
                r_out_last <= r_s1_last;
            end
        end
    end

    // Transfer counter: saturating, restarts after the last sample of a vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_xfer_count <= '0;
        end else if (w_out_xfer) begin
            if (r_out_last) begin
                r_xfer_count <= '0;
            end else if (r_xfer_count != CNT_MAX) begin
                r_xfer_count <= r_xfer_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sigmoid_backprop.sv
// Directed bench for sigmoid_backprop: table of hand-computed vectors plus
// explicit sequences for latency, stall/hold, simultaneous handshake, last and flush.
module tb_sigmoid_backprop;

    typedef struct packed {
        logic [9:0] y;
        logic [9:0] g;
        logic       last;
        logic [9:0] exp;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] y;
    logic [9:0] grad_in;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] grad_out;
    logic       out_last;
    logic [15:0] xfer_count;

    int checks;
    int errors;
    int stall_total;
    int model_cnt;
    vec_t tbl [15];
    vec_t exp_q [$];

    sigmoid_backprop #(.DATA_W(10), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .y          (y),
        .grad_in    (grad_in),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .grad_out   (grad_out),
        .out_last   (out_last),
        .xfer_count (xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int yv, input int gv, input bit lst, input int ev);
        vec_t v;
        v.y    = 10'(yv);
        v.g    = 10'(gv);
        v.last = lst;
        v.exp  = 10'(ev);
        return v;
    endfunction

    // Drive one sample starting at posedge+1; returns at posedge+1 after it is accepted.
    task automatic send(input vec_t v);
        int n;
        y        = v.y;
        grad_in  = v.g;
        in_last  = v.last;
        in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            stall_total++;
            if (n > 50) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({"drain_", name}, exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Output monitor: every output transfer is compared against the expected queue.
    always @(negedge clk) begin
        vec_t e;
        if (rst) begin
            model_cnt = 0;
        end else if (out_valid && out_ready) begin
            chk("xfer_count_at_xfer", int'(xfer_count), model_cnt);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_output: got grad_out %0d, required no transfer",
                         $signed(grad_out));
            end else begin
                e = exp_q.pop_front();
                chk("grad_out", int'($signed(grad_out)), int'($signed(e.exp)));
                chk("out_last", int'(out_last), int'(e.last));
                if (e.last) model_cnt = 0;
                else if (model_cnt != 65535) model_cnt++;
            end
        end
    end

    initial begin
        checks      = 0;
        errors      = 0;
        stall_total = 0;
        model_cnt   = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        y           = '0;
        grad_in     = '0;
        in_last     = 1'b0;
        out_ready   = 1'b0;

        // Vector table: {y, grad_in, in_last, expected grad_out}
        tbl[0]  = mk(512,  256,  0,   64);   // latency probe, max dsig
        tbl[1]  = mk(100,  -512, 0,  -45);
        tbl[2]  = mk(768,  511,  0,   95);
        tbl[3]  = mk(0,    300,  0,    0);   // y = 0 -> dsig 0
        tbl[4]  = mk(1023, -300, 0,    0);   // y = max -> dsig 0
        tbl[5]  = mk(512,  -1,   0,   -1);   // floor toward -inf
        tbl[6]  = mk(256,  -100, 0,  -19);
        tbl[7]  = mk(512,  511,  0,  127);
        tbl[8]  = mk(900,  200,  0,   21);
        tbl[9]  = mk(512,  100,  0,   25);   // flushed by reset
        tbl[10] = mk(300,  -200, 0,  -42);   // flushed by reset
        tbl[11] = mk(512,  4,    0,    1);
        tbl[12] = mk(512,  -4,   0,   -1);
        tbl[13] = mk(256,  500,  0,   93);
        tbl[14] = mk(128,  -500, 1,  -55);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid",  int'(out_valid),  0);
        chk("rst_grad_out",   int'(grad_out),   0);
        chk("rst_out_last",   int'(out_last),   0);
        chk("rst_xfer_count", int'(xfer_count), 0);
        chk("rst_in_ready",   int'(in_ready),   1);

        // Single sample: out_valid appears 2 cycles after the input transfer
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        exp_q.push_back(tbl[0]);
        y        = tbl[0].y;
        grad_in  = tbl[0].g;
        in_last  = tbl[0].last;
        in_valid = 1'b1;
        @(negedge clk);
        chk("lat_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_cycle1_out_valid", int'(out_valid), 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("lat_cycle2_out_valid", int'(out_valid), 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("lat_xfer_count", int'(xfer_count), 1);
        chk("lat_out_valid_after", int'(out_valid), 0);
        @(posedge clk);
        #1;

        // Back-to-back stream, one sample per cycle
        stall_total = 0;
        for (int i = 1; i <= 5; i++) exp_q.push_back(tbl[i]);
        for (int i = 1; i <= 5; i++) send(tbl[i]);
        chk("stream_stalls", stall_total, 0);
        wait_drain("stream");

        // Backpressure: two samples absorbed, third refused, output held
        out_ready   = 1'b0;
        stall_total = 0;
        for (int i = 6; i <= 8; i++) exp_q.push_back(tbl[i]);
        send(tbl[6]);
        send(tbl[7]);
        chk("bp_two_accepted_stalls", stall_total, 0);
        y        = tbl[8].y;
        grad_in  = tbl[8].g;
        in_last  = tbl[8].last;
        in_valid = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_full", int'(in_ready), 0);
        chk("bp_out_valid",     int'(out_valid), 1);
        chk("bp_hold_grad",     int'($signed(grad_out)), -19);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("bp_hold_grad_stall", int'($signed(grad_out)), -19);
            chk("bp_in_ready_stall",  int'(in_ready), 0);
        end
        // Simultaneous input and output transfer on a full pipeline
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("simul_in_ready",  int'(in_ready), 1);
        chk("simul_out_valid", int'(out_valid), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("simul_occupancy_out_valid", int'(out_valid), 1);
        wait_drain("backpressure");

        // Reset with two samples in flight
        @(negedge clk);
        chk("pre_flush_xfer_count", int'(xfer_count), 9);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(tbl[9]);
        send(tbl[10]);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("flush_out_valid",  int'(out_valid),  0);
        chk("flush_grad_out",   int'(grad_out),   0);
        chk("flush_xfer_count", int'(xfer_count), 0);
        chk("flush_in_ready",   int'(in_ready),   1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("flush_no_output", int'(out_valid), 0);
        @(posedge clk);
        #1;

        // in_last on the 4th sample: counter 3 before that transfer, 0 after
        for (int i = 11; i <= 14; i++) exp_q.push_back(tbl[i]);
        for (int i = 11; i <= 14; i++) send(tbl[i]);
        wait_drain("last");
        @(negedge clk);
        chk("last_xfer_count_cleared", int'(xfer_count), 0);
        chk("last_out_valid_idle",     int'(out_valid),  0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
